// File: rtl/dmem_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_ctrl
//
// Shares one single-port, word-wide data memory between the core MEM stage
// (port core) and the debug/program loader (port dbg). Round-robin between the
// two, one transaction in flight at a time. The memory only ever sees
// full-word accesses. Byte/half load extraction and sign/zero extension are
// done here. SB/SH are performed as read-modify-write, so the memory block
// needs no byte enables.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   core_* / dbg_*             requester ports: req, we, func3, addr, wdata in;
//                              done out
//   rsp_rdata, rsp_err         shared response, valid while either done is high,
//                              held until the next done
//   mem_read_en, mem_write_en  memory enables (never both high, never in IDLE)
//   mem_func3                  constant full-word code 3'b010
//   mem_addr, mem_wdata        word-aligned address and full write word
//   mem_rdata                  combinational read word from the memory
//   fsmState                   current FSM state encoding, for observation
//
// Handshake: a requester raises req with we/func3/addr/wdata and holds them
// stable until its done pulses for exactly one cycle. While its own done is
// high, that port's req is ignored, so the requester may present the next
// transaction (or drop req) in that same cycle. Dropping req mid-transaction
// does not abort it.
// -----------------------------------------------------------------------------
module dmem_arbiter_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_func3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_done,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_func3,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_done,

    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,

    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic [2:0]        fsmState
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } stateType;

    // First byte address past the end of memory; one extra bit so the
    // comparison cannot wrap when the memory fills the whole address space.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * MEM_WORDS);

    stateType    state;
    logic        lastGrantDbg;   // 1 = dbg was granted last
    logic        ownerDbg;       // port owning the in-flight transaction
    logic [2:0]  opFunc3;
    logic [1:0]  opLane;         // byte offset within the word
    logic [15:0] opWdataLo;      // store data needed by the SB/SH merge

    assign mem_func3 = 3'b010;
    assign fsmState  = state;

    // -------------------------------------------------------------------------
    // Request legality
    // -------------------------------------------------------------------------
    function automatic logic illegalReq(input logic              we,
                                        input logic [2:0]        f3,
                                        input logic [ADDR_W-1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            default:                bad = 1'b0;
        endcase
        // Unsigned widths have no store form.
        if (we && (f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
        if ({1'b0, a} >= ADDR_LIMIT) bad = 1'b1;
        return bad;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration (evaluated only in IDLE)
    // -------------------------------------------------------------------------
    logic              coreEligible;
    logic              dbgEligible;
    logic              pickDbg;
    logic              anyGrant;
    logic              selWe;
    logic [2:0]        selFunc3;
    logic [ADDR_W-1:0] selAddr;
    logic [31:0]       selWdata;
    logic              selIllegal;

    always_comb begin
        coreEligible = core_req && !core_done;
        dbgEligible  = dbg_req && !dbg_done;
        anyGrant     = coreEligible || dbgEligible;
        // On a conflict the port that was not granted last wins.
        pickDbg      = dbgEligible && (!coreEligible || !lastGrantDbg);
        selWe        = pickDbg ? dbg_we    : core_we;
        selFunc3     = pickDbg ? dbg_func3 : core_func3;
        selAddr      = pickDbg ? dbg_addr  : core_addr;
        selWdata     = pickDbg ? dbg_wdata : core_wdata;
        selIllegal   = illegalReq(selWe, selFunc3, selAddr);
    end

    // -------------------------------------------------------------------------
    // Load lane extraction and extension
    // -------------------------------------------------------------------------
    logic [31:0] laneWord;
    logic [31:0] loadResult;

    always_comb begin
        laneWord = mem_rdata >> {opLane, 3'b000};
        case (opFunc3)
            3'b000:  loadResult = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b001:  loadResult = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b100:  loadResult = {24'd0, laneWord[7:0]};
            3'b101:  loadResult = {16'd0, laneWord[15:0]};
            default: loadResult = laneWord;
        endcase
    end

    // -------------------------------------------------------------------------
    // SB/SH merge: replace one byte or half lane of the word just read
    // -------------------------------------------------------------------------
    logic [31:0] mergedWord;

    always_comb begin
        mergedWord = mem_rdata;
        if (opFunc3 == 3'b000) begin
            case (opLane)
                2'd0:    mergedWord[7:0]   = opWdataLo[7:0];
                2'd1:    mergedWord[15:8]  = opWdataLo[7:0];
                2'd2:    mergedWord[23:16] = opWdataLo[7:0];
                default: mergedWord[31:24] = opWdataLo[7:0];
            endcase
        end else if (opLane[1]) begin
            mergedWord[31:16] = opWdataLo;
        end else begin
            mergedWord[15:0] = opWdataLo;
        end
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lastGrantDbg <= 1'b1;
            ownerDbg     <= 1'b0;
            opFunc3      <= 3'd0;
            opLane       <= 2'd0;
            opWdataLo    <= 16'd0;
            core_done    <= 1'b0;
            dbg_done     <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
        end else begin
            core_done <= 1'b0;
            dbg_done  <= 1'b0;

            case (state)
                IDLE: begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    if (anyGrant) begin
                        lastGrantDbg <= pickDbg;
                        ownerDbg     <= pickDbg;
                        opFunc3      <= selFunc3;
                        opLane       <= selAddr[1:0];
                        opWdataLo    <= selWdata[15:0];
                        if (selIllegal) begin
                            // Error completes straight from IDLE, no memory access.
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            core_done <= !pickDbg;
                            dbg_done  <= pickDbg;
                        end else begin
                            mem_addr <= {selAddr[ADDR_W-1:2], 2'b00};
                            if (!selWe) begin
                                state       <= LOAD;
                                mem_read_en <= 1'b1;
                            end else if (selFunc3 == 3'b010) begin
                                state        <= STORE;
                                mem_write_en <= 1'b1;
                                mem_wdata    <= selWdata;
                            end else begin
                                state       <= RMW_RD;
                                mem_read_en <= 1'b1;
                            end
                        end
                    end
                end

                LOAD: begin
                    mem_read_en <= 1'b0;
                    rsp_rdata   <= loadResult;
                    rsp_err     <= 1'b0;
                    core_done   <= !ownerDbg;
                    dbg_done    <= ownerDbg;
                    state       <= IDLE;
                end

                STORE: begin
                    mem_write_en <= 1'b0;
                    rsp_rdata    <= 32'd0;
                    rsp_err      <= 1'b0;
                    core_done    <= !ownerDbg;
                    dbg_done     <= ownerDbg;
                    state        <= IDLE;
                end

                RMW_RD: begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b1;
                    mem_wdata    <= mergedWord;
                    state        <= RMW_WR;
                end

                RMW_WR: begin
                    mem_write_en <= 1'b0;
                    rsp_rdata    <= 32'd0;
                    rsp_err      <= 1'b0;
                    core_done    <= !ownerDbg;
                    dbg_done     <= ownerDbg;
                    state        <= IDLE;
                end

                default: begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter_ctrl
//
// Bench for dmem_arbiter_ctrl. A behavioural memory answers the DUT's memory
// port; a byte-level reference memory predicts every response, which is
// queued when a transaction is issued and compared when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter_ctrl;

    localparam int SB_W = 35;   // {core_done, dbg_done, rsp_err, rsp_rdata}

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txnType;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic        core_req, core_we, core_done;
    logic [2:0]  core_func3;
    logic [31:0] core_addr, core_wdata;
    logic        dbg_req, dbg_we, dbg_done;
    logic [2:0]  dbg_func3;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  fsmState;

    dmem_arbiter_ctrl #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_func3(core_func3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_done(core_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_func3(dbg_func3),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_done(dbg_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsmState(fsmState)
    );

    // ---------------- behavioural memory ----------------
    logic [31:0] memArr [0:1023];
    logic        memClear;
    logic [31:0] lastWrData;
    int          writeCount;
    int          accessCount;

    assign mem_rdata = memArr[mem_addr[11:2]];

    always @(posedge clock) begin
        if (memClear) begin
            for (int i = 0; i < 1024; i++) memArr[i] <= 32'd0;
            writeCount  <= 0;
            accessCount <= 0;
            lastWrData  <= 32'd0;
        end else begin
            if (mem_read_en || mem_write_en) accessCount <= accessCount + 1;
            if (mem_write_en) begin
                memArr[mem_addr[11:2]] <= mem_wdata;
                lastWrData <= mem_wdata;
                writeCount <= writeCount + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-port protocol: counted every cycle, reported once at the end.
    int bothEnViol = 0;
    int idleEnViol = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_read_en && mem_write_en) bothEnViol++;
            if (fsmState == 3'd0 && (mem_read_en || mem_write_en)) idleEnViol++;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0]     refMem [0:1023];
    logic [SB_W-1:0] exp_q[$];

    function automatic logic [SB_W-1:0] predict(input bit isDbg, input txnType t);
        logic        err;
        logic [31:0] data, w;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx, off;
        data = 32'd0;
        case (t.f3)
            3'b000, 3'b100: err = 1'b0;
            3'b001, 3'b101: err = t.addr[0];
            3'b010:         err = (t.addr[1:0] != 2'b00);
            default:        err = 1'b1;
        endcase
        if (t.we && (t.f3 == 3'b100 || t.f3 == 3'b101)) err = 1'b1;
        if (t.addr >= 32'h1000) err = 1'b1;
        if (!err) begin
            idx = int'(t.addr[11:2]);
            off = int'(t.addr[1:0]);
            w   = refMem[idx];
            b   = w[8*off +: 8];
            h   = t.addr[1] ? w[31:16] : w[15:0];
            if (!t.we) begin
                case (t.f3)
                    3'b000:  data = {{24{b[7]}}, b};
                    3'b001:  data = {{16{h[15]}}, h};
                    3'b100:  data = {24'd0, b};
                    3'b101:  data = {16'd0, h};
                    default: data = w;
                endcase
            end else begin
                case (t.f3)
                    3'b000:  w[8*off +: 8] = t.wdata[7:0];
                    3'b001:  if (t.addr[1]) w[31:16] = t.wdata[15:0];
                             else           w[15:0]  = t.wdata[15:0];
                    default: w = t.wdata;
                endcase
                refMem[idx] = w;
            end
        end
        return {~isDbg, isDbg, err, data};
    endfunction

    always @(negedge clock) begin
        logic [SB_W-1:0] e;
        if (!reset && (core_done || dbg_done)) begin
            checkEq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkEq("sb_resp", 64'({core_done, dbg_done, rsp_err, rsp_rdata}), 64'(e));
            end
        end
    end

    // ---------------- drivers ----------------
    txnType coreList[$];
    txnType dbgList[$];
    int     coreLat;
    int     dbgLat;

    // Issues every queued transaction of one port back to back, keeping req
    // high across them, and drops req after the last done.
    task automatic runPort(input bit isDbg);
        txnType t;
        int     n;
        logic   seen;
        @(negedge clock);
        while ((isDbg ? dbgList.size() : coreList.size()) != 0) begin
            if (isDbg) begin
                t = dbgList.pop_front();
                dbg_we = t.we; dbg_func3 = t.f3; dbg_addr = t.addr; dbg_wdata = t.wdata;
                dbg_req = 1'b1;
            end else begin
                t = coreList.pop_front();
                core_we = t.we; core_func3 = t.f3; core_addr = t.addr; core_wdata = t.wdata;
                core_req = 1'b1;
            end
            n = 0;
            do begin
                @(negedge clock);
                n++;
                seen = isDbg ? dbg_done : core_done;
            end while (!seen && n < 40);
            if (isDbg) dbgLat = n; else coreLat = n;
            if (!seen) checkEq(isDbg ? "dbg_timeout" : "core_timeout", 64'(seen), 64'd1);
        end
        if (isDbg) dbg_req = 1'b0; else core_req = 1'b0;
    endtask

    task automatic doTxn(input bit isDbg, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        txnType t;
        t = '{we: we, f3: f3, addr: addr, wdata: wdata};
        exp_q.push_back(predict(isDbg, t));
        if (isDbg) dbgList.push_back(t); else coreList.push_back(t);
        runPort(isDbg);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          ac0, wc0;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        int          k, off;

        core_req = 0; core_we = 0; core_func3 = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0;  dbg_we = 0;  dbg_func3 = 0;  dbg_addr = 0;  dbg_wdata = 0;
        for (int i = 0; i < 1024; i++) refMem[i] = 32'd0;
        reset = 1'b1;
        memClear = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);

        // Reset state
        checkEq("rst_core_done", 64'(core_done), 64'd0);
        checkEq("rst_dbg_done", 64'(dbg_done), 64'd0);
        checkEq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkEq("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkEq("rst_read_en", 64'(mem_read_en), 64'd0);
        checkEq("rst_write_en", 64'(mem_write_en), 64'd0);
        checkEq("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkEq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkEq("rst_state", 64'(fsmState), 64'd0);
        memClear = 1'b0;
        reset = 1'b0;

        // SW then byte loads of the same word
        doTxn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        checkEq("sw_latency", 64'(coreLat), 64'd2);
        checkEq("mem_func3", 64'(mem_func3), 64'd2);
        doTxn(0, 0, 3'b100, 32'h11, 32'd0);
        checkEq("lbu_0x11", 64'(rsp_rdata), 64'h000000BE);
        checkEq("load_latency", 64'(coreLat), 64'd2);
        doTxn(0, 0, 3'b000, 32'h13, 32'd0);
        checkEq("lb_0x13", 64'(rsp_rdata), 64'hFFFFFFDE);

        // Read-modify-write
        doTxn(1, 1, 3'b010, 32'h20, 32'h11223344);
        wc0 = writeCount;
        doTxn(0, 1, 3'b000, 32'h22, 32'h000000AA);
        checkEq("sb_latency", 64'(coreLat), 64'd3);
        checkEq("sb_merged", 64'(lastWrData), 64'h11AA3344);
        checkEq("sb_one_write", 64'(writeCount - wc0), 64'd1);
        doTxn(1, 0, 3'b010, 32'h20, 32'd0);
        doTxn(1, 1, 3'b001, 32'h22, 32'h1234BEEF);
        checkEq("sh_merged", 64'(lastWrData), 64'hBEEF3344);
        doTxn(0, 0, 3'b101, 32'h22, 32'd0);
        doTxn(0, 0, 3'b001, 32'h22, 32'd0);

        // Error cases: no memory access at all
        ac0 = accessCount;
        doTxn(0, 0, 3'b010, 32'h6, 32'd0);
        checkEq("lw_mis_err", 64'(rsp_err), 64'd1);
        checkEq("lw_mis_latency", 64'(coreLat), 64'd1);
        doTxn(0, 0, 3'b001, 32'h1000, 32'd0);
        checkEq("lh_oor_err", 64'(rsp_err), 64'd1);
        doTxn(1, 1, 3'b100, 32'h30, 32'h55);
        doTxn(1, 0, 3'b011, 32'h30, 32'd0);
        doTxn(0, 1, 3'b001, 32'h21, 32'h77);
        checkEq("err_no_access", 64'(accessCount - ac0), 64'd0);

        // Random single-port traffic
        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 9);
            rf3 = (k < 2) ? 3'b000 : (k < 4) ? 3'b001 : (k < 6) ? 3'b010 :
                  (k < 7) ? 3'b100 : (k < 8) ? 3'b101 : (k < 9) ? 3'b011 : 3'b110;
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                if (rf3 == 3'b010) off = 0;
                else if (rf3 == 3'b001 || rf3 == 3'b101) off = off & 2;
            end
            raddr = 32'($urandom_range(0, 15) * 4 + off);
            if ($urandom_range(0, 15) == 0) raddr = raddr + 32'h1000;
            doTxn(1'($urandom_range(0, 1)), rwe, rf3, raddr, $urandom);
        end

        // Reset in the middle of an SH read phase
        doTxn(1, 1, 3'b010, 32'h40, 32'h55667788);
        wc0 = writeCount;
        @(negedge clock);
        core_we = 1; core_func3 = 3'b001; core_addr = 32'h42; core_wdata = 32'h0000BEEF;
        core_req = 1;
        @(negedge clock);
        checkEq("rmw_rd_read_en", 64'(mem_read_en), 64'd1);
        checkEq("rmw_rd_addr", 64'(mem_addr), 64'h40);
        reset = 1'b1;
        #1;
        checkEq("midrst_read_en", 64'(mem_read_en), 64'd0);
        checkEq("midrst_write_en", 64'(mem_write_en), 64'd0);
        checkEq("midrst_mem_addr", 64'(mem_addr), 64'd0);
        checkEq("midrst_core_done", 64'(core_done), 64'd0);
        checkEq("midrst_state", 64'(fsmState), 64'd0);
        core_req = 0;
        @(negedge clock);
        reset = 1'b0;
        checkEq("midrst_no_write", 64'(writeCount - wc0), 64'd0);

        // Simultaneous requests after reset: core first, then strict alternation
        begin
            txnType c [3];
            txnType d [3];
            c[0] = '{we: 0, f3: 3'b010, addr: 32'h10, wdata: 32'd0};
            c[1] = '{we: 1, f3: 3'b010, addr: 32'h60, wdata: 32'hCAFEF00D};
            c[2] = '{we: 0, f3: 3'b100, addr: 32'h61, wdata: 32'd0};
            d[0] = '{we: 0, f3: 3'b010, addr: 32'h40, wdata: 32'd0};
            d[1] = '{we: 0, f3: 3'b010, addr: 32'h60, wdata: 32'd0};
            d[2] = '{we: 0, f3: 3'b001, addr: 32'h62, wdata: 32'd0};
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(predict(0, c[i]));
                exp_q.push_back(predict(1, d[i]));
                coreList.push_back(c[i]);
                dbgList.push_back(d[i]);
            end
        end
        fork
            runPort(0);
            runPort(1);
        join
        repeat (2) @(negedge clock);

        checkEq("sb_drained", 64'(exp_q.size()), 64'd0);
        checkEq("enables_exclusive", 64'(bothEnViol), 64'd0);
        checkEq("no_enable_in_idle", 64'(idleEnViol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
